// File: rtl/reduce_sum_unit_if.sv
// Handshake bundle between the matrix memory FSM and the REDUCE_SUM unit.
// The master drives block data and collects the scalar sum.
interface reduce_sum_unit_if #(
  parameter int LANES      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  logic                        start;
  logic [CNT_WIDTH-1:0]        num_blocks;
  logic                        in_valid;
  logic                        in_ready;
  logic [LANES*DATA_WIDTH-1:0] in_data;
  logic                        sum_valid;
  logic                        sum_ready;
  logic [DATA_WIDTH-1:0]       sum_data;
  logic                        busy;

  modport master (
    output start, num_blocks, in_valid, in_data, sum_ready,
    input  in_ready, sum_valid, sum_data, busy
  );

  modport slave (
    input  start, num_blocks, in_valid, in_data, sum_ready,
    output in_ready, sum_valid, sum_data, busy
  );
endinterface

// File: rtl/reduce_sum_unit.sv
// REDUCE_SUM engine: pipelined float32 adder tree -> partial-sum FIFO -> serial accumulator.
// Optional macro REDUCE_FLAGS_EN adds a sticky err output (NaN/overflow from any adder).
module reduce_sum_unit #(
  parameter int LANES      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADD_LAT    = 7,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic               clock,
  input  logic               reset,
  reduce_sum_unit_if.slave   bus
`ifdef REDUCE_FLAGS_EN
  ,
  output logic               err
`endif
);
  localparam int LEVELS   = $clog2(LANES);
  localparam int TREE_LAT = LEVELS * ADD_LAT;
  localparam int PTR_W    = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                state;
  logic [CNT_WIDTH-1:0]  nb, accepted, folded;
  logic [TREE_LAT-1:0]   tree_vld;
  logic [ADD_LAT-1:0]    acc_vld;
  logic [PTR_W:0]        fifo_cnt;
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] acc, acc_res;
  logic [DATA_WIDTH-1:0] node [1:2*LANES-1];
  logic                  accept, push, pop;
  int                    inflight;

  // IEEE-754 binary32 add, round-to-nearest-even; returns {nan, overflow, result}.
  function automatic logic [33:0] fp_add_core(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] a, b;
    logic [7:0]  ea, eb, d;
    logic [26:0] ma, mb, mask;
    logic [27:0] s;
    logic [9:0]  e;
    logic [24:0] mr;
    logic        sticky;
    if (x[30:0] >= y[30:0]) begin a = x; b = y; end
    else begin a = y; b = x; end
    if (a[30:23] == 8'hFF) begin
      if (a[22:0] != 23'd0 || (b[30:23] == 8'hFF && a[31] != b[31]))
        return {2'b10, 32'h7FC00000};
      return {2'b00, a};
    end
    ea = (a[30:23] == 8'd0) ? 8'd1 : a[30:23];
    eb = (b[30:23] == 8'd0) ? 8'd1 : b[30:23];
    ma = {a[30:23] != 8'd0, a[22:0], 3'b000};
    mb = {b[30:23] != 8'd0, b[22:0], 3'b000};
    d  = ea - eb;
    if (d > 8'd26) begin
      sticky = |mb;
      mb     = '0;
    end else begin
      mask   = (27'd1 << d) - 27'd1;
      sticky = |(mb & mask);
      mb     = mb >> d;
    end
    mb[0] = mb[0] | sticky;
    e = {2'b00, ea};
    if (a[31] == b[31]) begin
      s = {1'b0, ma} + {1'b0, mb};
      if (s[27]) begin
        s = {1'b0, s[27:2], s[1] | s[0]};
        e = e + 10'd1;
      end
    end else begin
      s = {1'b0, ma} - {1'b0, mb};
      if (s == 28'd0) return 34'd0;
      // Normalise left, stopping at the subnormal boundary.
      for (int i = 0; i < 26; i++)
        if (!s[26] && e > 10'd1) begin
          s = s << 1;
          e = e - 10'd1;
        end
    end
    mr = {1'b0, s[26:3]} + {24'd0, s[2] & (s[1] | s[0] | s[3])};
    if (mr[24]) begin
      mr = mr >> 1;
      e  = e + 10'd1;
    end
    if (e >= 10'd255) return {2'b01, a[31], 8'hFF, 23'd0};
    return {2'b00, a[31], mr[23] ? e[7:0] : 8'd0, mr[22:0]};
  endfunction

  function automatic logic [31:0] fp_sum(input logic [31:0] a, input logic [31:0] b);
    return 32'(fp_add_core(a, b));
  endfunction

`ifdef REDUCE_FLAGS_EN
  function automatic logic fp_flag(input logic [31:0] a, input logic [31:0] b);
    return fp_add_core(a, b) >= 34'h1_0000_0000;
  endfunction

  logic [2*LANES-1:1] node_flag;
  logic               acc_flag;
`endif

  // Tree stage: heap-indexed nodes, leaves at LANES..2*LANES-1, root at 1.
  for (genvar i = 0; i < LANES; i++) begin : g_leaf
    assign node[LANES+i] = bus.in_data[i*DATA_WIDTH +: DATA_WIDTH];
`ifdef REDUCE_FLAGS_EN
    assign node_flag[LANES+i] = 1'b0;
`endif
  end

  for (genvar k = 1; k < LANES; k++) begin : g_add
    logic [DATA_WIDTH-1:0] sum_pipe [ADD_LAT];
    always_ff @(posedge clock) begin
      sum_pipe[0] <= fp_sum(node[2*k], node[2*k+1]);
      for (int s = 1; s < ADD_LAT; s++) sum_pipe[s] <= sum_pipe[s-1];
    end
    assign node[k] = sum_pipe[ADD_LAT-1];
`ifdef REDUCE_FLAGS_EN
    logic flag_pipe [ADD_LAT];
    always_ff @(posedge clock) begin
      flag_pipe[0] <= fp_flag(node[2*k], node[2*k+1]) | node_flag[2*k] | node_flag[2*k+1];
      for (int s = 1; s < ADD_LAT; s++) flag_pipe[s] <= flag_pipe[s-1];
    end
    assign node_flag[k] = flag_pipe[ADD_LAT-1];
`endif
  end

  // FIFO / accumulator stage
  logic [DATA_WIDTH-1:0] acc_pipe [ADD_LAT];
  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= node[1];
    acc_pipe[0] <= fp_sum(acc, fifo_mem[rd_ptr]);
    for (int s = 1; s < ADD_LAT; s++) acc_pipe[s] <= acc_pipe[s-1];
  end
  assign acc_res = acc_pipe[ADD_LAT-1];

`ifdef REDUCE_FLAGS_EN
  logic accf_pipe [ADD_LAT];
  always_ff @(posedge clock) begin
    accf_pipe[0] <= fp_flag(acc, fifo_mem[rd_ptr]);
    for (int s = 1; s < ADD_LAT; s++) accf_pipe[s] <= accf_pipe[s-1];
  end
  assign acc_flag = accf_pipe[ADD_LAT-1];
`endif

  always_comb begin
    inflight = 0;
    for (int i = 0; i < TREE_LAT; i++) inflight += int'(tree_vld[i]);
  end

  // Credits cover both stored and in-flight tree results, so the FIFO cannot overflow.
  assign bus.in_ready  = (state == RUN) && (accepted < nb) &&
                         (int'(fifo_cnt) + inflight < FIFO_DEPTH);
  assign accept        = bus.in_valid & bus.in_ready;
  assign push          = tree_vld[TREE_LAT-1];
  assign pop           = (fifo_cnt != '0) && !(|acc_vld);
  assign bus.sum_valid = (state == DONE);
  assign bus.sum_data  = acc;
  assign bus.busy      = (state != IDLE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      nb       <= '0;
      accepted <= '0;
      folded   <= '0;
      tree_vld <= '0;
      acc_vld  <= '0;
      fifo_cnt <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      acc      <= '0;
`ifdef REDUCE_FLAGS_EN
      err      <= 1'b0;
`endif
    end else begin
      tree_vld <= {tree_vld[TREE_LAT-2:0], accept};
      acc_vld  <= {acc_vld[ADD_LAT-2:0], pop};
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      fifo_cnt <= fifo_cnt + 1'b1;
      else if (pop && !push) fifo_cnt <= fifo_cnt - 1'b1;
      if (accept) accepted <= accepted + 1'b1;
      if (acc_vld[ADD_LAT-1]) begin
        acc    <= acc_res;
        folded <= folded + 1'b1;
      end
`ifdef REDUCE_FLAGS_EN
      if (push && node_flag[1])              err <= 1'b1;
      if (acc_vld[ADD_LAT-1] && acc_flag)    err <= 1'b1;
`endif
      case (state)
        IDLE: if (bus.start) begin
          nb       <= bus.num_blocks;
          accepted <= '0;
          folded   <= '0;
          acc      <= '0;
`ifdef REDUCE_FLAGS_EN
          err      <= 1'b0;
`endif
          state    <= (bus.num_blocks == '0) ? DONE : RUN;
        end
        RUN:   if (accepted == nb) state <= DRAIN;
        DRAIN: if (folded == nb)   state <= DONE;
        DONE:  if (bus.sum_ready)  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
